// File: rtl/riscv_run_ctrl.sv
// Run-control unit for the single-cycle RISC-V core: free-run, halt, single-step,
// EBREAK stop and cycle/instret counters. Define RUN_CTRL_BP_EN to build the PC breakpoint.
module riscv_run_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter bit          RESET_RUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  localparam logic [2:0] CAUSE_RESET = 3'b000;
  localparam logic [2:0] CAUSE_HALT  = 3'b001;
  localparam logic [2:0] CAUSE_STEP  = 3'b010;
  localparam logic [2:0] CAUSE_BP    = 3'b011;
  localparam logic [2:0] CAUSE_EBRK  = 3'b100;

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             skip_q, skip_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             bp_hit, ebrk, stop_now;

`ifdef RUN_CTRL_BP_EN
  assign bp_hit = bp_en && (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{bp_en, bp_addr, pc};
`endif

  assign ebrk     = (instr == EBREAK_INSN);
  assign stop_now = bp_hit | ebrk;

  // State, skip flag, cause and counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RESET_RUN ? S_RUN : S_HALTED;
      skip_q    <= 1'b1;
      cause_q   <= CAUSE_RESET;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_q + CNT_W'(1);
      instret_q <= instret_q + CNT_W'(cpu_en);
    end
  end

  // Next state and commit enable; the first instruction after leaving HALTED
  // bypasses the stop checks so a resume does not re-halt on the same PC.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cause_d = cause_q;
    cpu_en  = 1'b0;
    case (state_q)
      S_HALTED: begin
        if (halt_req) begin
          cause_d = CAUSE_HALT;
        end else if (step_req) begin
          state_d = S_STEP;
          skip_d  = 1'b1;
        end else if (run_req) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      S_RUN: begin
        cpu_en = skip_q | ~stop_now;
        if (cpu_en) skip_d = 1'b0;
        if (halt_req) begin
          state_d = S_HALTED;
          cause_d = CAUSE_HALT;
        end else if (!skip_q && bp_hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_BP;
        end else if (!skip_q && ebrk) begin
          state_d = S_HALTED;
          cause_d = CAUSE_EBRK;
        end
      end
      S_STEP: begin
        cpu_en  = 1'b1;
        skip_d  = 1'b0;
        state_d = S_HALTED;
        cause_d = halt_req ? CAUSE_HALT : CAUSE_STEP;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
    if (!rst) cpu_en = 1'b0;
  end

  assign halted      = (state_q == S_HALTED);
  assign halt_cause  = cause_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: directed scenarios followed by random
// stimulus, each cycle checked against a behavioural run-control model.
module tb_riscv_run_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam int          CMASK = (1 << CNT_W) - 1;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef RUN_CTRL_BP_EN
  localparam bit BP_BUILT = 1'b1;
`else
  localparam bit BP_BUILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, bp_en = 1'b0;
  logic [XLEN-1:0]  bp_addr = '0, pc = '0;
  logic [31:0]      instr = NOP;
  logic             cpu_en, halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  riscv_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .RESET_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr), .cpu_en(cpu_en),
    .halted(halted), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       hlt;
    logic [2:0] cause;
    int         cyc;
    int         ret;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: what the core is doing, in plain terms
  string m_mode  = "halted";
  bit    m_fresh = 1'b1;   // next instruction is the first after a resume
  int    m_cause = 0;
  int    m_cyc   = 0;
  int    m_ret   = 0;
  logic [31:0] pc_v = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // One clock of stimulus; the expected outputs of that cycle go to the scoreboard
  task automatic cyc(input logic r, input logic rr, input logic hr, input logic sr,
                     input logic be, input logic [31:0] ba, input logic [31:0] p,
                     input logic [31:0] ins);
    exp_t e;
    bit   stop, commit;
    @(posedge clk); #1;
    rst = r; run_req = rr; halt_req = hr; step_req = sr;
    bp_en = be; bp_addr = ba; pc = p; instr = ins;
    stop = (BP_BUILT && be && p == ba) || ins == EBRK;
    commit = r && (m_mode == "step" || (m_mode == "run" && (m_fresh || !stop)));
    e.en = commit; e.hlt = (m_mode == "halted"); e.cause = 3'(m_cause);
    e.cyc = m_cyc; e.ret = m_ret;
    exp_q.push_back(e);
    if (!r) begin
      m_mode = "halted"; m_fresh = 1'b1; m_cause = 0; m_cyc = 0; m_ret = 0;
    end else begin
      m_cyc = (m_cyc + 1) & CMASK;
      if (commit) begin
        m_ret = (m_ret + 1) & CMASK;
        pc_v  = pc_v + 32'd4;
      end
      if (m_mode == "halted") begin
        if (hr) m_cause = 1;
        else if (sr) begin m_mode = "step"; m_fresh = 1'b1; end
        else if (rr) begin m_mode = "run"; m_fresh = 1'b1; end
      end else if (m_mode == "step") begin
        m_mode = "halted"; m_cause = hr ? 1 : 2;
      end else begin
        if (hr) begin m_mode = "halted"; m_cause = 1; end
        else if (!m_fresh && BP_BUILT && be && p == ba) begin m_mode = "halted"; m_cause = 3; end
        else if (!m_fresh && ins == EBRK) begin m_mode = "halted"; m_cause = 4; end
        if (commit) m_fresh = 1'b0;
      end
    end
  endtask

  // Sequential program fetch at pc_v with the given requests
  task automatic seq(input int n, input logic rr, input logic hr, input logic sr,
                     input logic be, input logic [31:0] ins);
    for (int i = 0; i < n; i++) cyc(1'b1, rr, hr, sr, be, 32'h10, pc_v, ins);
  endtask

  // Monitor: one output sample per cycle, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cpu_en",      32'(cpu_en),      32'(e.en));
      chk("halted",      32'(halted),      32'(e.hlt));
      chk("halt_cause",  32'(halt_cause),  32'(e.cause));
      chk("cycle_cnt",   32'(cycle_cnt),   32'(e.cyc));
      chk("instret_cnt", 32'(instret_cnt), 32'(e.ret));
    end
  end

  initial begin
    // reset, then run pulse and free run
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, NOP);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, NOP);
    seq(2, 1'b0, 1'b0, 1'b0, 1'b0, NOP);
    seq(1, 1'b1, 1'b0, 1'b0, 1'b0, NOP);
    seq(10, 1'b0, 1'b0, 1'b0, 1'b0, NOP);
    seq(1, 1'b0, 1'b1, 1'b0, 1'b0, NOP);
    // breakpoint at 0x10 and resume across it
    pc_v = '0;
    seq(1, 1'b1, 1'b0, 1'b0, 1'b1, NOP);
    seq(8, 1'b0, 1'b0, 1'b0, 1'b1, NOP);
    seq(1, 1'b1, 1'b0, 1'b0, 1'b1, NOP);
    seq(4, 1'b0, 1'b0, 1'b0, 1'b1, NOP);
    seq(1, 1'b0, 1'b1, 1'b0, 1'b0, NOP);
    // three single steps
    for (int k = 0; k < 3; k++) begin
      seq(1, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
      seq(2, 1'b0, 1'b0, 1'b0, 1'b0, NOP);
    end
    // ebreak stop, then all requests together
    seq(1, 1'b1, 1'b0, 1'b0, 1'b0, NOP);
    seq(4, 1'b0, 1'b0, 1'b0, 1'b0, EBRK);
    seq(2, 1'b1, 1'b1, 1'b1, 1'b0, NOP);
    // reset during a step cycle
    seq(1, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, pc_v, NOP);
    seq(2, 1'b0, 1'b0, 1'b0, 1'b0, NOP);
    // long free run so both counters wrap
    seq(1, 1'b1, 1'b0, 1'b0, 1'b0, NOP);
    seq(300, 1'b0, 1'b0, 1'b0, 1'b0, NOP);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] p, ba, ins;
      p   = 32'($urandom_range(0, 7)) << 2;
      ba  = ($urandom_range(0, 3) != 0) ? 32'h10 : (32'($urandom_range(0, 7)) << 2);
      ins = ($urandom_range(0, 7) == 0) ? EBRK : $urandom;
      cyc(($urandom_range(0, 399) != 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), ba, p, ins);
    end
    @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_run_ctrl.md
# riscv_run_ctrl

Run-control unit that sequences the single-cycle RISC-V core. It owns the core's commit enable and decides, cycle by cycle, whether the instruction at the current `pc` is allowed to commit. It supports free-run, halt, single-step, a PC breakpoint and EBREAK detection, and keeps cycle and retired-instruction counters. It sits between the debug/test harness and `riscv_cpu`. `cpu_en` gates the PC register update, register-file write and data-memory write.

## Interface
- `XLEN`, 32, width of `pc`, `instr` and `bp_addr`.
- `CNT_W`, 32, width of `cycle_cnt` and `instret_cnt`.
- `RESET_RUN`, 0, state after reset: 0 = HALTED, 1 = RUN.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on posedge `clk`.
- `run_req`  in  1  level request to leave HALTED and free-run.
- `halt_req`  in  1  level request to stop.
- `step_req`  in  1  request to execute exactly one instruction from HALTED.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  XLEN  breakpoint PC.
- `pc`  in  XLEN  core's current PC.
- `instr`  in  32  core's current fetched instruction.
- `cpu_en`  out  1  commit enable to the core (combinational).
- `halted`  out  1  state == HALTED.
- `halt_cause`  out  3  000 reset, 001 halt_req, 010 step done, 011 breakpoint, 100 ebreak.
- `cycle_cnt`  out  CNT_W  clock cycles since reset.
- `instret_cnt`  out  CNT_W  cycles with `cpu_en`=1.

## Operation
- State machine states: HALTED, RUN, STEP. Internal flag `skip` marks the first instruction after leaving HALTED.
- `cpu_en` = `rst` & (STEP | (RUN & (skip | !stop_now))).
  - stop_now = bp_hit | ebrk.
  - bp_hit = `bp_en` & (`pc` == `bp_addr`).
  - ebrk = (`instr` == 32'h0010_0073).
- HALTED:
  - `halt_req` keeps the state HALTED and sets cause 001.
  - Otherwise `step_req` goes to STEP.
  - Otherwise `run_req` goes to RUN.
  - Leaving HALTED sets `skip`=1.
- RUN, checked in priority order:
  - `halt_req` → HALTED, cause 001. The current instruction still commits (`cpu_en`=1 this cycle).
  - Otherwise, with !skip & bp_hit → HALTED, cause 011, nothing commits.
  - Otherwise, with !skip & ebrk → HALTED, cause 100, nothing commits.
  - Otherwise stay in RUN.
  - `skip` clears after any committed cycle.
- STEP: `cpu_en`=1 for exactly one cycle, then HALTED with cause 010. Breakpoint and EBREAK checks are skipped. A `halt_req` in the STEP cycle gives cause 001 instead.
- Resume semantics: run or step from a breakpoint/EBREAK PC executes that instruction, so the core does not re-halt on the same PC.
- Counters:
  - `cycle_cnt` increments every non-reset cycle.
  - `instret_cnt` increments when `cpu_en`=1.
  - Both wrap modulo 2^CNT_W with no saturation and no flag.

## Timing
- Reset (`rst`=0 at posedge) forces:
  - state = RESET_RUN ? RUN : HALTED;
  - `skip`=1, `halt_cause`=000, both counters = 0.
- During reset cycles `cpu_en`=0 combinationally. Reset mid-RUN or mid-STEP aborts with no commit in that cycle.
- `halted` is 1 after reset when RESET_RUN=0, and 0 when RESET_RUN=1.
- `halt_req`, `run_req` and `step_req` take effect at the next posedge. Requests ignored in a state are dropped, not queued.
- Breakpoint and EBREAK block commit in the same cycle: combinational path `pc`/`instr` → `cpu_en`.
- `halted` rises one cycle after the stopping condition.
- `halt_cause` updates on entry to HALTED and holds until the next entry or reset.
- Step latency: `step_req` in cycle N gives `cpu_en`=1 in cycle N+1 and `halted`=1 in N+2.
- Simultaneous requests resolve halt > step > run.

## Configuration
- `RUN_CTRL_BP_EN` defined: breakpoint comparator built as described.
- Not defined: bp_hit is tied to 0. `bp_en` and `bp_addr` are ignored and cause 011 never occurs. EBREAK, halt and step behaviour is unchanged.

## Test plan
- RESET_RUN=0, reset 2 cycles, then `run_req` pulse → `cpu_en`=0 until the cycle after the pulse, then 1. `instret_cnt` = 10 after 10 RUN cycles. `cycle_cnt` counts all cycles.
- RUN, `bp_en`=1, `bp_addr`=0x0000_0010 → `cpu_en`=0 when `pc`=0x10, `halted`=1 next cycle, cause 011. A `run_req` then commits pc 0x10 and continues.
- HALTED, three `step_req` pulses (one per 3 cycles) → exactly 3 cycles with `cpu_en`=1, `instret_cnt` +3, cause 010 after each.
- RUN, `instr`=0x0010_0073 → no commit, cause 100. With `halt_req`, `step_req` and `run_req` all high in HALTED → stays HALTED, cause 001.
- `rst`=0 asserted in a STEP cycle → `cpu_en`=0 that cycle, both counters 0, cause 000. Counter preset via `force` to 2^32−1 → wraps to 0.
- Build without `RUN_CTRL_BP_EN`, same breakpoint stimulus as the second scenario → no halt at 0x10, `cpu_en` stays 1.
